// File: rtl/trap_entry_seq_pkg.sv
// rtl/trap_entry_seq_pkg.sv - shared state type and CSR addresses for the trap-entry sequencer
package trap_entry_seq_pkg;

  typedef enum logic [2:0] {
    TS_IDLE,
    TS_DRAIN,
    TS_WEPC,
    TS_WCAUSE,
    TS_WTVAL,
    TS_WSTAT,
    TS_REDIR
  } trapseq_state_t;

  localparam logic [11:0] MEPC_ADR   = 12'h341;
  localparam logic [11:0] MCAUSE_ADR = 12'h342;
  localparam logic [11:0] MTVAL_ADR  = 12'h343;
  localparam logic [11:0] SEPC_ADR   = 12'h141;
  localparam logic [11:0] SCAUSE_ADR = 12'h142;
  localparam logic [11:0] STVAL_ADR  = 12'h143;

  function automatic logic [11:0] priv_adr(input logic to_s, input logic [11:0] s_adr,
                                           input logic [11:0] m_adr);
    return to_s ? s_adr : m_adr;
  endfunction

endpackage

// File: rtl/trap_entry_seq_trapvec.sv
// rtl/trap_entry_seq_trapvec.sv - trap vector select and vectored-interrupt target computation
module trap_entry_seq_trapvec #(
  parameter int XLEN = 64
) (
  input  logic            to_s,
  input  logic            interrupt,
  input  logic [3:0]      cause,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] stvec,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] tvec;
  logic [XLEN-1:0] base;

  always_comb begin
    tvec   = to_s ? stvec : mtvec;
    base   = {tvec[XLEN-1:2], 2'b00};
    target = base;
    // Vectored mode only offsets interrupts; the sum is allowed to wrap.
    if (interrupt && (tvec[1:0] == 2'b01)) begin
      target = base + {{(XLEN-6){1'b0}}, cause, 2'b00};
    end
  end

endmodule

// File: rtl/trap_entry_seq.sv
// rtl/trap_entry_seq.sv - trap-entry sequencer: drain, xEPC/xCAUSE/xTVAL writes, status update, redirect
module trap_entry_seq
  import trap_entry_seq_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit S_SUPPORTED = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            TrapM,
  input  logic            InterruptM,
  input  logic            DelegateM,
  input  logic [3:0]      CauseM,
  input  logic [XLEN-1:0] PCM,
  input  logic [XLEN-1:0] TvalM,
  input  logic            CommittedM,
  input  logic [XLEN-1:0] MTVEC,
  input  logic [XLEN-1:0] STVEC,
  input  logic            InstrCSRWrEn,
  input  logic [11:0]     InstrCSRAdr,
  input  logic [XLEN-1:0] InstrCSRData,
  output logic            InstrCSRStall,
  output logic            CSRWrEn,
  output logic [11:0]     CSRWrAdr,
  output logic [XLEN-1:0] CSRWrData,
  output logic            StatusTrapUpd,
  output logic            StatusToS,
  output logic            RedirValid,
  input  logic            RedirReady,
  output logic [XLEN-1:0] RedirPC,
  output logic            TrapBusy
);

  trapseq_state_t  state_q, state_d;
  logic            intr_q, intr_d;
  logic            tos_q, tos_d;
  logic [3:0]      cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic [XLEN-1:0] vec_target;

  trap_entry_seq_trapvec #(.XLEN(XLEN)) u_trapvec (
    .to_s      (tos_q),
    .interrupt (intr_q),
    .cause     (cause_q),
    .mtvec     (MTVEC),
    .stvec     (STVEC),
    .target    (vec_target)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= TS_IDLE;
      intr_q     <= 1'b0;
      tos_q      <= 1'b0;
      cause_q    <= '0;
      pc_q       <= '0;
      tval_q     <= '0;
      redir_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      intr_q     <= intr_d;
      tos_q      <= tos_d;
      cause_q    <= cause_d;
      pc_q       <= pc_d;
      tval_q     <= tval_d;
      redir_pc_q <= redir_pc_d;
    end
  end

  assign TrapBusy = (state_q != TS_IDLE);

  always_comb begin
    state_d       = state_q;
    intr_d        = intr_q;
    tos_d         = tos_q;
    cause_d       = cause_q;
    pc_d          = pc_q;
    tval_d        = tval_q;
    redir_pc_d    = redir_pc_q;
    InstrCSRStall = 1'b0;
    CSRWrEn       = 1'b0;
    CSRWrAdr      = '0;
    CSRWrData     = '0;
    StatusTrapUpd = 1'b0;
    StatusToS     = 1'b0;
    RedirValid    = 1'b0;
    RedirPC       = '0;

    unique case (state_q)
      TS_IDLE: begin
        // Outputs stay quiet while reset is held, even on the pass-through path.
        if (reset_n) begin
          if (TrapM) begin
            intr_d        = InterruptM;
            tos_d         = DelegateM & S_SUPPORTED;
            cause_d       = CauseM;
            pc_d          = PCM;
            tval_d        = TvalM;
            state_d       = CommittedM ? TS_DRAIN : TS_WEPC;
            InstrCSRStall = 1'b1;
          end else begin
            CSRWrEn   = InstrCSRWrEn;
            CSRWrAdr  = InstrCSRAdr;
            CSRWrData = InstrCSRData;
          end
        end
      end
      TS_DRAIN: begin
        InstrCSRStall = InstrCSRWrEn;
        if (!CommittedM) state_d = TS_WEPC;
      end
      TS_WEPC: begin
        InstrCSRStall = InstrCSRWrEn;
        CSRWrEn       = 1'b1;
        CSRWrAdr      = priv_adr(tos_q, SEPC_ADR, MEPC_ADR);
        CSRWrData     = {pc_q[XLEN-1:1], 1'b0};
        state_d       = TS_WCAUSE;
      end
      TS_WCAUSE: begin
        InstrCSRStall = InstrCSRWrEn;
        CSRWrEn       = 1'b1;
        CSRWrAdr      = priv_adr(tos_q, SCAUSE_ADR, MCAUSE_ADR);
        CSRWrData     = {intr_q, {(XLEN-5){1'b0}}, cause_q};
        state_d       = TS_WTVAL;
      end
      TS_WTVAL: begin
        InstrCSRStall = InstrCSRWrEn;
        CSRWrEn       = 1'b1;
        CSRWrAdr      = priv_adr(tos_q, STVAL_ADR, MTVAL_ADR);
        CSRWrData     = intr_q ? '0 : tval_q;
        state_d       = TS_WSTAT;
      end
      TS_WSTAT: begin
        InstrCSRStall = InstrCSRWrEn;
        StatusTrapUpd = 1'b1;
        StatusToS     = tos_q;
        // Capture the target here so RedirPC cannot move while fetch is stalling.
        redir_pc_d    = vec_target;
        state_d       = TS_REDIR;
      end
      TS_REDIR: begin
        InstrCSRStall = InstrCSRWrEn;
        RedirValid    = 1'b1;
        RedirPC       = redir_pc_q;
        if (RedirReady) state_d = TS_IDLE;
      end
      default: state_d = TS_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trap_entry_seq.sv
// tb/tb_trap_entry_seq.sv - self-checking bench for trap_entry_seq against a cycle-by-cycle reference model
module tb_trap_entry_seq;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            TrapM, InterruptM, DelegateM, CommittedM;
  logic [3:0]      CauseM;
  logic [XLEN-1:0] PCM, TvalM, MTVEC, STVEC;
  logic            InstrCSRWrEn;
  logic [11:0]     InstrCSRAdr;
  logic [XLEN-1:0] InstrCSRData;
  logic            InstrCSRStall, CSRWrEn, StatusTrapUpd, StatusToS, RedirValid, RedirReady, TrapBusy;
  logic [11:0]     CSRWrAdr;
  logic [XLEN-1:0] CSRWrData, RedirPC;

  int n_tests = 0;
  int n_fail  = 0;
  int tid     = 0;

  always #5 clk = ~clk;

  trap_entry_seq #(.XLEN(XLEN), .S_SUPPORTED(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .TrapM(TrapM), .InterruptM(InterruptM), .DelegateM(DelegateM),
    .CauseM(CauseM), .PCM(PCM), .TvalM(TvalM), .CommittedM(CommittedM), .MTVEC(MTVEC), .STVEC(STVEC),
    .InstrCSRWrEn(InstrCSRWrEn), .InstrCSRAdr(InstrCSRAdr), .InstrCSRData(InstrCSRData),
    .InstrCSRStall(InstrCSRStall), .CSRWrEn(CSRWrEn), .CSRWrAdr(CSRWrAdr), .CSRWrData(CSRWrData),
    .StatusTrapUpd(StatusTrapUpd), .StatusToS(StatusToS), .RedirValid(RedirValid),
    .RedirReady(RedirReady), .RedirPC(RedirPC), .TrapBusy(TrapBusy)
  );

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_instr(input logic hold);
    InstrCSRWrEn = hold ? 1'b1 : 1'($urandom_range(0, 1));
    InstrCSRAdr  = 12'($urandom);
    InstrCSRData = rnd64();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wren"}, 64'(CSRWrEn), 64'd0);
    chk({tag, "_adr"}, 64'(CSRWrAdr), 64'd0);
    chk({tag, "_data"}, CSRWrData, 64'd0);
    chk({tag, "_stall"}, 64'(InstrCSRStall), 64'd0);
    chk({tag, "_stat"}, 64'(StatusTrapUpd), 64'd0);
    chk({tag, "_stos"}, 64'(StatusToS), 64'd0);
    chk({tag, "_rv"}, 64'(RedirValid), 64'd0);
    chk({tag, "_rpc"}, RedirPC, 64'd0);
    chk({tag, "_busy"}, 64'(TrapBusy), 64'd0);
  endtask

  // Idle with no trap: the instruction write path is a straight pass-through.
  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 64'(TrapBusy), 64'd0);
    chk({tag, "_wren"}, 64'(CSRWrEn), 64'(InstrCSRWrEn));
    chk({tag, "_adr"}, 64'(CSRWrAdr), 64'(InstrCSRAdr));
    chk({tag, "_data"}, CSRWrData, InstrCSRData);
    chk({tag, "_stall"}, 64'(InstrCSRStall), 64'd0);
    chk({tag, "_rv"}, 64'(RedirValid), 64'd0);
    chk({tag, "_stat"}, 64'(StatusTrapUpd), 64'd0);
  endtask

  // One full trap: cycle 0 is the IDLE cycle with TrapM=1, CommittedM high for `drain` cycles,
  // RedirReady withheld for `rdelay` REDIR cycles. Caller sets MTVEC/STVEC beforehand.
  task automatic run_trap(input logic intr, input logic deleg, input logic [3:0] cause,
                          input logic [63:0] pc, input logic [63:0] tval,
                          input int drain, input int rdelay, input logic hold);
    logic [63:0] tvec, exp_pc;
    logic [63:0] wdata [3];
    logic [11:0] wadr [3];
    logic [11:0] adr_base;
    int          last, p;
    tid++;
    tvec   = deleg ? STVEC : MTVEC;
    exp_pc = tvec & ~64'h3;
    if (intr && tvec[1:0] == 2'b01) exp_pc = exp_pc + 64'(cause) * 64'd4;
    adr_base = deleg ? 12'h140 : 12'h340;
    for (int i = 0; i < 3; i++) wadr[i] = adr_base + 12'(i + 1);
    wdata[0] = pc & ~64'h1;
    wdata[1] = (64'(intr) << 63) | 64'(cause);
    wdata[2] = intr ? 64'd0 : tval;

    @(posedge clk); #1;
    TrapM = 1'b1; InterruptM = intr; DelegateM = deleg; CauseM = cause; PCM = pc; TvalM = tval;
    CommittedM = (drain > 0); RedirReady = 1'($urandom_range(0, 1));
    drive_instr(hold);
    @(negedge clk);
    chk($sformatf("t%0d_c0_busy", tid), 64'(TrapBusy), 64'd0);
    chk($sformatf("t%0d_c0_wren", tid), 64'(CSRWrEn), 64'd0);
    chk($sformatf("t%0d_c0_stall", tid), 64'(InstrCSRStall), 64'd1);

    last = drain + 5 + rdelay;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      p = k - drain;
      TrapM = 1'($urandom_range(0, 1)); InterruptM = 1'($urandom_range(0, 1));
      DelegateM = 1'($urandom_range(0, 1)); CauseM = 4'($urandom); PCM = rnd64(); TvalM = rnd64();
      CommittedM = (k < drain) ? 1'b1 : (k == drain) ? 1'b0 : 1'($urandom_range(0, 1));
      RedirReady = (p >= 5) ? (p >= 5 + rdelay) : 1'($urandom_range(0, 1));
      drive_instr(hold);
      @(negedge clk);
      if (p >= 1 && p <= 3) begin
        chk($sformatf("t%0d_k%0d_wren", tid, k), 64'(CSRWrEn), 64'd1);
        chk($sformatf("t%0d_k%0d_adr", tid, k), 64'(CSRWrAdr), 64'(wadr[p-1]));
        chk($sformatf("t%0d_k%0d_data", tid, k), CSRWrData, wdata[p-1]);
      end else begin
        chk($sformatf("t%0d_k%0d_wren", tid, k), 64'(CSRWrEn), 64'd0);
        chk($sformatf("t%0d_k%0d_adr", tid, k), 64'(CSRWrAdr), 64'd0);
        chk($sformatf("t%0d_k%0d_data", tid, k), CSRWrData, 64'd0);
      end
      chk($sformatf("t%0d_k%0d_stat", tid, k), 64'(StatusTrapUpd), 64'(p == 4));
      chk($sformatf("t%0d_k%0d_stos", tid, k), 64'(StatusToS), 64'(p == 4 && deleg));
      chk($sformatf("t%0d_k%0d_rv", tid, k), 64'(RedirValid), 64'(p >= 5));
      chk($sformatf("t%0d_k%0d_rpc", tid, k), RedirPC, (p >= 5) ? exp_pc : 64'd0);
      chk($sformatf("t%0d_k%0d_busy", tid, k), 64'(TrapBusy), 64'd1);
      chk($sformatf("t%0d_k%0d_stall", tid, k), 64'(InstrCSRStall), 64'(InstrCSRWrEn));
    end

    @(posedge clk); #1;
    TrapM = 1'b0; CommittedM = 1'($urandom_range(0, 1)); RedirReady = 1'b0;
    drive_instr(hold);
    @(negedge clk);
    check_idle($sformatf("t%0d_end", tid));
  endtask

  initial begin
    reset_n = 1'b0;
    TrapM = 1'b0; InterruptM = 1'b0; DelegateM = 1'b0; CauseM = '0; PCM = '0; TvalM = '0;
    CommittedM = 1'b0; MTVEC = '0; STVEC = '0; RedirReady = 1'b0;
    InstrCSRWrEn = 1'b0; InstrCSRAdr = '0; InstrCSRData = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Exception to M, vectored interrupt to M, delegated exception to S.
    MTVEC = 64'h8000_0000; STVEC = 64'h4000_0200;
    run_trap(1'b0, 1'b0, 4'd2, 64'h8000_0104, 64'hDEAD, 0, 0, 1'b0);
    MTVEC = 64'h8000_0001;
    run_trap(1'b1, 1'b0, 4'd7, 64'h8000_0200, 64'h1234, 0, 0, 1'b0);
    run_trap(1'b0, 1'b1, 4'd13, 64'h8000_0301, 64'hBEEF, 0, 0, 1'b0);
    // Drain, held instruction write, slow redirect acceptance.
    run_trap(1'b0, 1'b0, 4'd5, 64'h8000_0400, 64'h55, 3, 0, 1'b0);
    run_trap(1'b0, 1'b0, 4'd3, 64'h8000_0500, 64'h66, 1, 2, 1'b1);
    run_trap(1'b1, 1'b1, 4'd9, 64'h8000_0600, 64'h77, 0, 4, 1'b0);
    // Vectored target wraps past the top of the address space.
    MTVEC = 64'hFFFF_FFFF_FFFF_FFF1;
    run_trap(1'b1, 1'b0, 4'd15, 64'h10, 64'h0, 0, 0, 1'b0);

    // Asynchronous reset in the middle of WCAUSE.
    MTVEC = 64'h8000_0000;
    @(posedge clk); #1;
    TrapM = 1'b1; InterruptM = 1'b0; DelegateM = 1'b0; CauseM = 4'd4; PCM = 64'h8000_0700;
    TvalM = 64'h99; CommittedM = 1'b0; InstrCSRWrEn = 1'b1;
    @(posedge clk); #1;
    TrapM = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wcause_wren", 64'(CSRWrEn), 64'd1);
    chk("rst_wcause_adr", 64'(CSRWrAdr), 64'h342);
    #2;
    reset_n = 1'b0;
    TrapM = 1'b1;
    #1;
    check_all_zero("rst_async");
    @(posedge clk); #1;
    check_all_zero("rst_held");
    TrapM = 1'b0; InstrCSRWrEn = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("rst_release");
    run_trap(1'b0, 1'b0, 4'd6, 64'h8000_0800, 64'hABCD, 0, 1, 1'b0);

    // Randomized traps against the reference model.
    for (int n = 0; n < 25; n++) begin
      MTVEC = rnd64();
      STVEC = rnd64();
      if ($urandom_range(0, 1) == 1) MTVEC[1:0] = 2'b01;
      if ($urandom_range(0, 1) == 1) STVEC[1:0] = 2'b01;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        TrapM = 1'b0;
        drive_instr(1'b0);
        @(negedge clk);
        check_idle($sformatf("idle_r%0d", n));
      end
      run_trap(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom), rnd64(), rnd64(),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
